// File: rtl/cpu_pkg.sv
// Shared core constants: datapath/register-index widths and write-back result selects.
package cpu_pkg;

  localparam int unsigned N      = 32;
  localparam int unsigned ADDR_W = 5;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, RAW/WAW stall to decode.
// With WB_FORWARD_EN the retiring write is masked out of the hazard lookup.
module reg_scoreboard #(
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] issue_rs1,
  input  logic [ADDR_W-1:0] issue_rs2,
  input  logic              rf_write,
  input  logic [ADDR_W-1:0] rf_rd,
  output logic              stall
);

  localparam int unsigned NumRegs = 1 << ADDR_W;

  logic [NumRegs-1:0] busy_q, busy_d;
  logic               hz_rs1, hz_rs2, hz_rd;

  always_comb begin
    hz_rs1 = (issue_rs1 != '0) & busy_q[issue_rs1];
    hz_rs2 = (issue_rs2 != '0) & busy_q[issue_rs2];
    hz_rd  = (issue_rd  != '0) & busy_q[issue_rd];
`ifdef WB_FORWARD_EN
    // The retiring value is forwarded, so its register is no longer a hazard.
    if (rf_write && (rf_rd == issue_rs1)) hz_rs1 = 1'b0;
    if (rf_write && (rf_rd == issue_rs2)) hz_rs2 = 1'b0;
    if (rf_write && (rf_rd == issue_rd))  hz_rd  = 1'b0;
`endif
    stall = issue_valid & (hz_rs1 | hz_rs2 | hz_rd);
  end

  always_comb begin
    busy_d = busy_q;
    if (rf_write) busy_d[rf_rd] = 1'b0;
    // Set after clear so a coinciding new writer keeps the bit.
    if (issue_valid && !stall && (issue_rd != '0)) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

endmodule

// File: rtl/reg_writeback.sv
// Write-back stage: MEM/WB register, result select, register-file write driver,
// commit counter and hazard scoreboard. Optional macro WB_FORWARD_EN adds forwarding.
import cpu_pkg::*;

module reg_writeback #(
  parameter int unsigned N      = cpu_pkg::N,
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] issue_rs1,
  input  logic [ADDR_W-1:0] issue_rs2,
  output logic              stall,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [1:0]        mem_wb_sel,
  input  logic [N-1:0]      mem_alu_result,
  input  logic [N-1:0]      mem_load_data,
  input  logic [N-1:0]      mem_pc_plus4,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [N-1:0]      rf_write_data,
  output logic [31:0]       wb_count
`ifdef WB_FORWARD_EN
  ,
  output logic              fwd_rs1_hit,
  output logic              fwd_rs2_hit,
  output logic [N-1:0]      fwd_data
`endif
);

  logic [N-1:0] wb_result;

  always_comb begin
    case (mem_wb_sel)
      WB_SEL_LOAD: wb_result = mem_load_data;
      WB_SEL_PC4:  wb_result = mem_pc_plus4;
      default:     wb_result = mem_alu_result;
    endcase
  end

  // The register file writes combinationally, so these must only move on edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_write      <= 1'b0;
      rf_rd         <= '0;
      rf_write_data <= '0;
      wb_count      <= '0;
    end else begin
      rf_write      <= mem_valid & mem_reg_write & (mem_rd != '0);
      rf_rd         <= mem_rd;
      rf_write_data <= wb_result;
      if (rf_write) wb_count <= wb_count + 32'd1;
    end
  end

  reg_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .issue_rs1  (issue_rs1),
    .issue_rs2  (issue_rs2),
    .rf_write   (rf_write),
    .rf_rd      (rf_rd),
    .stall      (stall)
  );

`ifdef WB_FORWARD_EN
  assign fwd_rs1_hit = rf_write & (rf_rd == issue_rs1) & (issue_rs1 != '0);
  assign fwd_rs2_hit = rf_write & (rf_rd == issue_rs2) & (issue_rs2 != '0);
  assign fwd_data    = rf_write_data;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Directed self-checking bench for reg_writeback; forwarding checks when WB_FORWARD_EN is set.
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        stall;
  logic        mem_valid, mem_reg_write;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;
  logic [31:0] mem_alu_result, mem_load_data, mem_pc_plus4;
  logic        rf_write;
  logic [4:0]  rf_rd;
  logic [31:0] rf_write_data;
  logic [31:0] wb_count;
`ifdef WB_FORWARD_EN
  logic        fwd_rs1_hit, fwd_rs2_hit;
  logic [31:0] fwd_data;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_writeback dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .issue_rs1     (issue_rs1),
    .issue_rs2     (issue_rs2),
    .stall         (stall),
    .mem_valid     (mem_valid),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_wb_sel    (mem_wb_sel),
    .mem_alu_result(mem_alu_result),
    .mem_load_data (mem_load_data),
    .mem_pc_plus4  (mem_pc_plus4),
    .rf_write      (rf_write),
    .rf_rd         (rf_rd),
    .rf_write_data (rf_write_data),
    .wb_count      (wb_count)
`ifdef WB_FORWARD_EN
    ,
    .fwd_rs1_hit   (fwd_rs1_hit),
    .fwd_rs2_hit   (fwd_rs2_hit),
    .fwd_data      (fwd_data)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
    mem_valid = 1'b0; mem_reg_write = 1'b0; mem_rd = '0; mem_wb_sel = 2'b00;
    mem_alu_result = '0; mem_load_data = '0; mem_pc_plus4 = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset rf_write", {31'd0, rf_write}, 32'd0);
    chk("reset rf_rd", {27'd0, rf_rd}, 32'd0);
    chk("reset rf_write_data", rf_write_data, 32'd0);
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("reset wb_count", wb_count, 32'd0);
  endtask

  task automatic test_select();
    logic [31:0] exp_data [4];
    exp_data[0] = 32'h11; exp_data[1] = 32'h22; exp_data[2] = 32'h33; exp_data[3] = 32'h11;
    mem_alu_result = 32'h11; mem_load_data = 32'h22; mem_pc_plus4 = 32'h33;
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd5;
    for (int i = 0; i < 4; i++) begin
      mem_wb_sel = 2'(i);
      tick();
      chk($sformatf("sel%0d data", i), rf_write_data, exp_data[i]);
      chk($sformatf("sel%0d rf_write", i), {31'd0, rf_write}, 32'd1);
      chk($sformatf("sel%0d rf_rd", i), {27'd0, rf_rd}, 32'd5);
      chk($sformatf("sel%0d wb_count", i), wb_count, 32'(i));
    end
    mem_valid = 1'b0;
    tick();
    chk("select final wb_count", wb_count, 32'd4);
    chk("select idle rf_write", {31'd0, rf_write}, 32'd0);
  endtask

  task automatic test_x0();
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd0; mem_alu_result = 32'hdead;
    tick();
    chk("x0 rf_write", {31'd0, rf_write}, 32'd0);
    mem_valid = 1'b0;
    tick();
    chk("x0 wb_count", wb_count, 32'd4);
  endtask

  task automatic test_raw_waw();
    issue_valid = 1'b1; issue_rd = 5'd7; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
    #1;
    chk("issue r7 stall", {31'd0, stall}, 32'd0);
    tick();
    // WAW: second writer of r7 must stall.
    issue_rd = 5'd7; issue_rs1 = 5'd0;
    #1;
    chk("waw stall", {31'd0, stall}, 32'd1);
    issue_rd = 5'd8; issue_rs1 = 5'd7;
    #1;
    chk("raw stall", {31'd0, stall}, 32'd1);
    tick();
    chk("raw stall held", {31'd0, stall}, 32'd1);
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd7; mem_wb_sel = 2'b00;
    mem_alu_result = 32'h77;
    tick();
    mem_valid = 1'b0;
    #1;
    chk("retire rf_write", {31'd0, rf_write}, 32'd1);
    chk("retire rf_rd", {27'd0, rf_rd}, 32'd7);
`ifdef WB_FORWARD_EN
    chk("fwd stall drop", {31'd0, stall}, 32'd0);
    chk("fwd rs1 hit", {31'd0, fwd_rs1_hit}, 32'd1);
    chk("fwd rs2 hit", {31'd0, fwd_rs2_hit}, 32'd0);
    chk("fwd data", fwd_data, 32'h77);
`else
    chk("raw stall in retire cycle", {31'd0, stall}, 32'd1);
    tick();
    chk("raw stall released", {31'd0, stall}, 32'd0);
`endif
    tick();
    issue_valid = 1'b0;
    // r8 was set by the released issue; dependent on r8 must now stall.
    issue_valid = 1'b1; issue_rd = 5'd9; issue_rs1 = 5'd8;
    #1;
    chk("r8 set after release", {31'd0, stall}, 32'd1);
    issue_valid = 1'b0;
  endtask

`ifdef WB_FORWARD_EN
  task automatic test_collision();
    issue_valid = 1'b1; issue_rd = 5'd10; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
    tick();
    issue_valid = 1'b0;
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd10; mem_alu_result = 32'h1010;
    tick();
    mem_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd10;
    #1;
    chk("collision no stall", {31'd0, stall}, 32'd0);
    tick();
    issue_rd = 5'd11; issue_rs1 = 5'd10;
    #1;
    chk("collision set wins", {31'd0, stall}, 32'd1);
    issue_valid = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_write();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd9; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
    tick();
    issue_valid = 1'b0;
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd9; mem_alu_result = 32'h99;
    tick();
    chk("pre-reset rf_write", {31'd0, rf_write}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_valid = 1'b0;
    chk("mid reset rf_write", {31'd0, rf_write}, 32'd0);
    chk("mid reset wb_count", wb_count, 32'd0);
    issue_valid = 1'b1; issue_rd = 5'd12; issue_rs1 = 5'd9;
    #1;
    chk("mid reset busy9 clear", {31'd0, stall}, 32'd0);
    issue_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_select();
    test_x0();
    test_raw_waw();
`ifdef WB_FORWARD_EN
    test_collision();
`endif
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-back stage and register-file write driver for the pipelined core. Captures the MEM-stage result into a MEM/WB pipeline register, selects the value to retire, and drives the register file's write port (`rd`, `write_data`, `mem_write`) from flops. It also keeps a 32-entry pending-write scoreboard that stalls decode on RAW/WAW hazards. Optionally, it forwards the retiring value to decode.

## Interface
Parameters:
- `N`, 32, datapath width
- `ADDR_W`, 5, register index width (32 registers)

Ports:
- `clk`  in  1  core clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `issue_valid`  in  1  decode presents an instruction that writes `issue_rd`
- `issue_rd`  in  ADDR_W  destination of the decode instruction
- `issue_rs1`, `issue_rs2`  in  ADDR_W  sources of the decode instruction
- `stall`  out  1  combinational hazard stall to decode
- `mem_valid`  in  1  MEM stage holds a valid instruction
- `mem_reg_write`  in  1  that instruction writes a register
- `mem_rd`  in  ADDR_W  its destination
- `mem_wb_sel`  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 ALU
- `mem_alu_result`, `mem_load_data`, `mem_pc_plus4`  in  N  candidate results
- `rf_write`  out  1  to register-file `mem_write`; registered
- `rf_rd`  out  ADDR_W  to register-file `rd`; registered
- `rf_write_data`  out  N  to register-file `write_data`; registered
- `wb_count`  out  32  number of committed register writes, wraps at 2^32
- `fwd_rs1_hit`, `fwd_rs2_hit`  out  1  (only with `WB_FORWARD_EN`) source matches the retiring write
- `fwd_data`  out  N  (only with `WB_FORWARD_EN`) equals `rf_write_data`

## Operation
- **Capture.** Each edge, the WB register loads:
  - `rf_write <= mem_valid & mem_reg_write & (mem_rd != 0)`
  - `rf_rd <= mem_rd`
  - `rf_write_data <= ` the selected result
- **x0 writes.** Writes to x0 are suppressed at capture. The register file has no x0 guard, so this is the only protection.
- **Change-only-on-edge rule.** The register file writes combinationally while `mem_write` is high. For that reason, `rf_write`, `rf_rd` and `rf_write_data` come straight from flops and change only at edges.
- **Scoreboard.** `busy[31:0]`; `busy[0]` is constant 0.
  - **Set:** `busy[issue_rd]` sets when `issue_valid & !stall & issue_rd != 0`.
  - **Clear:** `busy[rf_rd]` clears at the edge ending a cycle in which `rf_write = 1`.
  - **Simultaneous set and clear on the same index:** set wins.
- **Stall.** `stall = issue_valid & (hz(issue_rs1) | hz(issue_rs2) | hz(issue_rd))`, where `hz(r) = (r != 0) & busy[r]`.
  - The `issue_rd` term covers WAW: one outstanding writer per register.
  - A stalled issue sets nothing.
- **`wb_count`.** Increments by 1 on each edge where `rf_write = 1`.

## Timing
- **Reset values.** After a reset edge:
  - `rf_write = 0`, `rf_rd = 0`, `rf_write_data = 0`
  - `busy = 0`, `wb_count = 0`
  - `stall` follows busy, so it is 0
- **Reset mid-operation.** A pending write is dropped. `rf_write` is 0 in the cycle after the reset edge.
- **Latency.** MEM input at edge k appears on `rf_*` during cycle k+1. The register file is written during cycle k+1, and busy clears at edge k+2.
- **Stall release.** Without forwarding, a dependent instruction stalls through cycle k+1 and issues in cycle k+2.
- **Back-to-back writes.** One write per cycle is sustained; a new capture overwrites the WB register every edge.

## Configuration
- **`WB_FORWARD_EN` defined:**
  - `fwd_rsX_hit = rf_write & (rf_rd == issue_rsX) & (issue_rsX != 0)`
  - `hz(r)` excludes `r` when `rf_write & rf_rd == r`, so stall drops in cycle k+1 and decode uses `fwd_data`.
  - The WAW term on `issue_rd` is also masked in that case. A new set that coincides with the clear wins.
- **`WB_FORWARD_EN` undefined:** the `fwd_*` ports are absent and the stall holds until the busy bit clears. This costs one extra cycle per RAW hazard.

## Structure
- **`cpu_pkg`** holds:
  - `N`, `ADDR_W`
  - `WB_SEL_ALU=2'b00`, `WB_SEL_LOAD=2'b01`, `WB_SEL_PC4=2'b10`
- **Sub-module `reg_scoreboard`:** owns the busy vector, set/clear priority and the `hz()` lookup. It outputs `stall`.
- **`reg_writeback`:** owns the WB register, result mux and counter.

## Test plan
- **Reset then idle:** `rst` high 2 cycles, then low with all valids 0 → `rf_write=0`, `rf_rd=0`, `rf_write_data=0`, `stall=0`, `wb_count=0`.
- **Select mux:** MEM writes to rd=5, one per cycle, with `mem_wb_sel` 00/01/10/11 and ALU=0x11, load=0x22, pc4=0x33 → `rf_write_data` is 0x11, 0x22, 0x33, 0x11 on consecutive cycles; `rf_rd=5`; `wb_count` reaches 4.
- **x0 suppression:** `mem_rd=0`, `mem_reg_write=1`, `mem_valid=1` → `rf_write` stays 0 and `wb_count` is unchanged.
- **RAW hazard:** issue rd=7. While r7 is outstanding, decode presents rs1=7 → `stall=1` until the write completes.
  - Without the macro, stall releases the cycle after `rf_write`/`rf_rd=7`.
  - With the macro, stall drops during the `rf_write` cycle, `fwd_rs1_hit=1` and `fwd_data` equals the written value.
- **WAW and set/clear collision:**
  - A second issue with rd=7 while r7 is busy → `stall=1`, no set.
  - Under `WB_FORWARD_EN`, an issue with rd=7 in the same cycle r7 retires → `busy[7]` remains 1 afterward.
- **Reset mid-write:** `rst` asserted in the cycle a write to r9 is captured → `rf_write=0` next cycle, `busy[9]=0`, `wb_count=0`.
